// File: rtl/key_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// key_conditioner_pkg
//   Shared types and helpers for the push-button conditioner.
//   - rpt_state_t : auto-repeat FSM states
//   - DEF_*       : default timing constants for a 25 MHz clock
//   - cnt_width / tmr_width : counter widths derived from the timing parameters
// -----------------------------------------------------------------------------
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_t;

    localparam int DEF_N_KEYS          = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = 12500000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 2500000;   // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The debounce counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

    // One timer serves both the initial delay and the repeat period.
    function automatic int tmr_width(input int repeat_delay, input int repeat_period);
        return $clog2(max_int(repeat_delay, repeat_period) + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_conditioner_if
//   Bundle between the board pins / game core and the conditioner.
//   KEY_N       : raw active-low buttons (asynchronous)
//   BTN_HELD    : debounced level, 1 = pressed
//   BTN_PRESS   : one-cycle pulse per debounced press
//   BTN_RELEASE : one-cycle pulse per debounced release
//   BTN_REPEAT  : one-cycle pulse on press and on each auto-repeat tick
//   dbg_state   : per-channel auto-repeat FSM state
//   There is no valid/ready handshake on this bundle: every signal is either a
//   level or a single-cycle pulse, and the consumer samples it on every clock.
//   master = board/core side, slave = conditioner side.
// -----------------------------------------------------------------------------
interface key_conditioner_if
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS = DEF_N_KEYS
);
    logic [N_KEYS-1:0]      KEY_N;
    logic [N_KEYS-1:0]      BTN_HELD;
    logic [N_KEYS-1:0]      BTN_PRESS;
    logic [N_KEYS-1:0]      BTN_RELEASE;
    logic [N_KEYS-1:0]      BTN_REPEAT;
    rpt_state_t [N_KEYS-1:0] dbg_state;

    modport master (
        output KEY_N,
        input  BTN_HELD, BTN_PRESS, BTN_RELEASE, BTN_REPEAT, dbg_state
    );

    modport slave (
        input  KEY_N,
        output BTN_HELD, BTN_PRESS, BTN_RELEASE, BTN_REPEAT, dbg_state
    );
endinterface

// File: rtl/key_conditioner_channel.sv
// -----------------------------------------------------------------------------
// key_conditioner_channel
//   One button: 2-flop synchroniser, counter debounce, press/release pulses and
//   auto-repeat FSM.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_n        : raw active-low button
//   btn_held     : debounced level (1 = pressed)
//   btn_press    : pulse on debounced press
//   btn_release  : pulse on debounced release
//   btn_repeat   : pulse on press and each auto-repeat tick
//   dbg_state    : auto-repeat FSM state
// -----------------------------------------------------------------------------
module key_conditioner_channel
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic       btn_held,
    output logic       btn_press,
    output logic       btn_release,
    output logic       btn_repeat,
    output rpt_state_t dbg_state
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int TMR_W = tmr_width(REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Clamped so a disabled repeat (delay 0) still yields a legal constant.
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(((REPEAT_DELAY > 0) ? REPEAT_DELAY : 1) - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

    // ---------------- synchroniser (resets to "released") ----------------
    logic s1, s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    // ---------------- debounce ----------------
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             key_lvl;
    logic             mismatch;
    logic             flip;
    logic             rise;
    logic             fall;

    assign key_lvl  = ~s2;
    assign mismatch = (key_lvl != stable);
    assign flip     = mismatch && (cnt == CNT_LAST);
    assign rise     = flip && !stable;
    assign fall     = flip && stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable      <= 1'b0;
            cnt         <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= rise;
            btn_release <= fall;
            if (!mismatch) begin
                cnt <= '0;
            end else if (flip) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign btn_held = stable;

    // ---------------- auto-repeat FSM ----------------
    rpt_state_t       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             rpt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            btn_repeat <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            btn_repeat <= rpt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rpt_d   = 1'b0;
        // Release is checked first so it beats a coincident timer expiry.
        if (fall) begin
            state_d = IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        rpt_d = 1'b1;
                        tmr_d = '0;
                        if (REPEAT_DELAY > 0) begin
                            state_d = DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (tmr_q == DLY_LAST) begin
                        rpt_d   = 1'b1;
                        state_d = RPT;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                RPT: begin
                    if (tmr_q == PER_LAST) begin
                        rpt_d = 1'b1;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    assign dbg_state = state_q;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   Conditions raw active-low push-buttons for the Pong core (25 MHz domain).
//   CLK_25MHZ : pixel clock, sole clock domain
//   RESET_N   : asynchronous active-low reset
//   keys      : key_conditioner_if.slave (KEY_N in; BTN_HELD, BTN_PRESS,
//               BTN_RELEASE, BTN_REPEAT, dbg_state out)
//   Integration: BTN_UP <= BTN_HELD[0], BTN_DOWN <= BTN_HELD[1].
// -----------------------------------------------------------------------------
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS          = DEF_N_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                     CLK_25MHZ,
    input  logic                     RESET_N,
    key_conditioner_if.slave         keys
);
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("key_conditioner: REPEAT_PERIOD must be >= 1");
    end
    if (REPEAT_DELAY < 0) begin : g_bad_delay
        $error("key_conditioner: REPEAT_DELAY must be >= 0");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_conditioner_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (CLK_25MHZ),
            .rst_n       (RESET_N),
            .key_n       (keys.KEY_N[i]),
            .btn_held    (keys.BTN_HELD[i]),
            .btn_press   (keys.BTN_PRESS[i]),
            .btn_release (keys.BTN_RELEASE[i]),
            .btn_repeat  (keys.BTN_REPEAT[i]),
            .dbg_state   (keys.dbg_state[i])
        );
    end

endmodule
